// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit-side feeder.
// Contents: default data width / FIFO address width and the launch FSM
// state encoding used by uart_tx_feeder.
package uart_pkg;

  localparam int DBIT_DEF   = 8;
  localparam int ADDR_W_DEF = 4;

  // Launch FSM encoding; 2'b11 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LAUNCH = 2'b01,
    ST_WAIT   = 2'b10
  } state_t;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: bundle of the host write side and transmitter side
// signals of uart_tx_feeder.
//   master modport (host/transmitter side): drives wr_en, wr_data,
//     tx_done_tick; observes full, empty, count, overflow, tx_start,
//     tx_dout, busy.
//   slave modport (feeder side): the reverse.
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              wr_en;
  logic [DBIT-1:0]   wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              tx_start;
  logic [DBIT-1:0]   tx_dout;
  logic              tx_done_tick;
  logic              busy;

  modport master (
    output wr_en, wr_data, tx_done_tick,
    input  full, empty, count, overflow, tx_start, tx_dout, busy
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick,
    output full, empty, count, overflow, tx_start, tx_dout, busy
  );

endinterface

// File: rtl/uart_tx_feeder_sync_fifo.sv
// sync_fifo: circular FIFO of 2**ADDR_W words with a separate occupancy
// counter and a sticky overflow flag.
// Ports: clk, reset (sync, active-high); wr_en/wr_data write side;
// rd_en/rd_data read side (rd_data shows the head word combinationally);
// full, empty, count, overflow status.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DBIT-1:0]   wr_data,
  input  logic              rd_en,
  output logic [DBIT-1:0]   rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [DBIT-1:0]   mem_r [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic              overflow_r;
  logic              full_s;
  logic              empty_s;
  logic              wr_acc_s;
  logic              rd_acc_s;

  // A write while full is rejected even if a pop frees a slot this cycle.
  assign full_s   = (count_r == DEPTH);
  assign empty_s  = (count_r == {(ADDR_W+1){1'b0}});
  assign wr_acc_s = wr_en && !full_s;
  assign rd_acc_s = rd_en && !empty_s;

  assign rd_data  = mem_r[rd_ptr_r];
  assign full     = full_s;
  assign empty    = empty_s;
  assign count    = count_r;
  assign overflow = overflow_r;

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + ONE;
        2'b01:   count_r <= count_r - ONE;
        default: count_r <= count_r;
      endcase
      if (wr_en && full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes in a FIFO and launches them one at a
// time into the UART transmitter, waiting for tx_done_tick between frames.
// Ports: clk, reset (sync, active-high); bus (slave modport) carrying
// wr_en/wr_data/full/empty/count/overflow on the host side and
// tx_start/tx_dout/tx_done_tick/busy on the transmitter side.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DBIT   = DBIT_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_feeder_if.slave   bus
);

  state_t            state_r;
  logic              tx_start_r;
  logic [DBIT-1:0]   tx_dout_r;
  logic              busy_r;
  logic              fifo_rd_en_s;
  logic [DBIT-1:0]   fifo_rd_data_s;
  logic              fifo_empty_s;

  // Pop only from IDLE; the FSM captures the head word on the same edge.
  assign fifo_rd_en_s = (state_r == ST_IDLE) && !fifo_empty_s;

  sync_fifo #(
    .DBIT   (DBIT),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.wr_en),
    .wr_data  (bus.wr_data),
    .rd_en    (fifo_rd_en_s),
    .rd_data  (fifo_rd_data_s),
    .full     (bus.full),
    .empty    (fifo_empty_s),
    .count    (bus.count),
    .overflow (bus.overflow)
  );

  assign bus.empty    = fifo_empty_s;
  assign bus.tx_start = tx_start_r;
  assign bus.tx_dout  = tx_dout_r;
  assign bus.busy     = busy_r;

  // Launch FSM; tx_start and busy are registered next-state decodes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tx_start_r <= 1'b0;
      tx_dout_r  <= {DBIT{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            state_r    <= ST_LAUNCH;
            tx_start_r <= 1'b1;
            tx_dout_r  <= fifo_rd_data_s;
            busy_r     <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
            tx_start_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          state_r    <= ST_WAIT;
          tx_start_r <= 1'b0;
          busy_r     <= 1'b1;
        end
        ST_WAIT: begin
          tx_start_r <= 1'b0;
          if (bus.tx_done_tick) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_WAIT;
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          tx_start_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed scoreboard bench for uart_tx_feeder.
// Expected bytes are queued as writes are driven; a launch monitor records
// each observed tx_start (byte and cycle) and the main sequence pops and
// compares them.
module tb_uart_tx_feeder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   wr_cyc = 0;
  int   done_cyc = 0;
  int   double_pulse = 0;
  logic prev_start = 1'b0;

  logic [7:0] exp_q [$];
  logic [7:0] obs_d [$];
  int         obs_c [$];

  uart_tx_feeder_if bus ();

  uart_tx_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Launch monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      obs_d.push_back(bus.tx_dout);
      obs_c.push_back(cyc);
      if (prev_start === 1'b1) double_pulse <= double_pulse + 1;
    end
    prev_start <= bus.tx_start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit acc);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (acc) exp_q.push_back(d);
    tick();
    bus.wr_en = 1'b0;
    wr_cyc    = cyc;
  endtask

  task automatic done();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    done_cyc = cyc;
  endtask

  // Wait (bounded) for the next launch and score it; exp_cyc < 0 skips timing.
  task automatic get_launch(input int exp_cyc);
    int t = 0;
    logic [7:0] e;
    while (obs_d.size() == 0 && t < 100) begin
      tick();
      t++;
    end
    chk("launch_seen", 32'(obs_d.size() != 0), 32'd1);
    if (obs_d.size() != 0) begin
      chk("exp_available", 32'(exp_q.size() != 0), 32'd1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
      chk("tx_dout", 32'(obs_d.pop_front()), 32'(e));
      t = obs_c.pop_front();
      if (exp_cyc >= 0) chk("launch_latency", t, exp_cyc);
    end
  endtask

  initial begin
    int w1;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.tx_done_tick = 1'b0;

    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_dout", bus.tx_dout, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    tick();

    // Single byte
    wr(8'hA5, 1'b1);
    chk("t1_empty_after_wr", bus.empty, 0);
    get_launch(wr_cyc + 1);
    chk("t1_busy", bus.busy, 1);
    repeat (5) tick();
    chk("t1_busy_hold", bus.busy, 1);
    chk("t1_tx_dout_stable", bus.tx_dout, 8'hA5);
    chk("t1_count", bus.count, 0);
    done();
    chk("t1_busy_clear", bus.busy, 0);
    chk("t1_empty", bus.empty, 1);

    // Three back-to-back writes, done 20 cycles after each launch
    wr(8'h11, 1'b1);
    w1 = wr_cyc;
    wr(8'h22, 1'b1);
    wr(8'h33, 1'b1);
    get_launch(w1 + 1);
    for (int k = 0; k < 2; k++) begin
      repeat (19) tick();
      done();
      get_launch(done_cyc + 1);
    end
    repeat (19) tick();
    done();
    chk("t2_empty", bus.empty, 1);

    // Fill to full with done held low; 18th write dropped
    for (int i = 0; i < 17; i++) begin
      wr(8'h40 + 8'(i), 1'b1);
      if (i == 0) w1 = wr_cyc;
    end
    chk("t3_count_full", bus.count, 16);
    chk("t3_full", bus.full, 1);
    chk("t3_no_overflow_yet", bus.overflow, 0);
    wr(8'hFF, 1'b0);
    chk("t3_overflow", bus.overflow, 1);
    chk("t3_count_hold", bus.count, 16);
    get_launch(w1 + 1);

    // Full FIFO, IDLE pop cycle with a write: write rejected
    done();
    wr(8'hEE, 1'b0);
    chk("t4_count_15", bus.count, 15);
    chk("t4_not_full", bus.full, 0);
    get_launch(done_cyc + 1);

    // Flush before the wrap test
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    obs_d.delete();
    obs_c.delete();
    chk("flush_overflow", bus.overflow, 0);

    // 20 bytes through the FIFO: pointer wrap
    for (int i = 0; i < 20; i++) begin
      wr(8'(i), 1'b1);
      get_launch(wr_cyc + 1);
      repeat (3) tick();
      done();
    end
    chk("t5_overflow", bus.overflow, 0);
    chk("t5_empty", bus.empty, 1);

    // Reset in WAIT with 5 bytes queued
    for (int i = 0; i < 6; i++) begin
      wr(8'h60 + 8'(i), 1'b1);
      if (i == 0) w1 = wr_cyc;
    end
    get_launch(w1 + 1);
    chk("t6_count_5", bus.count, 5);
    chk("t6_busy", bus.busy, 1);
    reset = 1'b1;
    tick();
    chk("t6_rst_count", bus.count, 0);
    chk("t6_rst_empty", bus.empty, 1);
    chk("t6_rst_tx_start", bus.tx_start, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_tx_dout", bus.tx_dout, 0);
    reset = 1'b0;
    exp_q.delete();
    obs_d.delete();
    obs_c.delete();
    wr(8'h7E, 1'b1);
    get_launch(wr_cyc + 1);
    done();
    chk("t6_busy_end", bus.busy, 0);

    repeat (10) tick();
    chk("no_extra_launch", obs_d.size(), 0);
    chk("single_cycle_start", double_pulse, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
